// File: rtl/bus_master_if.sv
// Core request/response and device-bus signals of the bus_master initiator.
// The master modport is the initiator's view; slave is the core/decoder/device side.
interface bus_master_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int NDEV   = 7
);
    logic                     req_valid;
    logic                     req_ready;
    logic                     req_we;
    logic [ADDR_W-1:0]        req_addr;
    logic [DATA_W-1:0]        req_wdata;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [DATA_W-1:0]        rsp_rdata;
    logic                     rsp_err;
    logic [2:0]               rsp_did;
    logic                     bus_rd;
    logic                     bus_wr;
    logic [ADDR_W-1:0]        bus_addr;
    logic [DATA_W-1:0]        bus_wdata;
    logic                     bus_hit;
    logic [2:0]               bus_did;
    logic [NDEV-1:0]          dev_ack;
    logic [NDEV*DATA_W-1:0]   dev_rdata;

    modport master (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
        input  bus_hit, bus_did, dev_ack, dev_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_did,
        output bus_rd, bus_wr, bus_addr, bus_wdata
    );

    modport slave (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
        output bus_hit, bus_did, dev_ack, dev_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_did,
        input  bus_rd, bus_wr, bus_addr, bus_wdata
    );
endinterface

// File: rtl/bus_master.sv
// Single-outstanding memory-bus initiator: IDLE -> ISSUE -> (WAIT) -> RESP.
// Optional WAIT timeout is enabled by defining BUS_TIMEOUT_EN.
module bus_master #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int NDEV    = 7,
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rst,
    bus_master_if.master  bif
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    if (NDEV < 1 || NDEV > 8) begin : g_bad_ndev
        $error("bus_master: NDEV must fit a 3-bit device id");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("bus_master: TIMEOUT must be at least 1");
    end

    state_t              state_q, state_d;
    logic                req_ready_q, req_ready_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q, rsp_err_d;
    logic [2:0]          rsp_did_q, rsp_did_d;
    logic                bus_rd_q, bus_rd_d;
    logic                bus_wr_q, bus_wr_d;
    logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0]   bus_wdata_q, bus_wdata_d;
    logic [2:0]          sel_q, sel_d;
`ifdef BUS_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0]    cnt_q, cnt_d;
`endif

    logic [DATA_W-1:0]   dev_rdata_arr [NDEV];
    logic                issue_ack, wait_ack, did_ok;
    logic [DATA_W-1:0]   issue_data, wait_data;

    genvar gi;
    generate
        for (gi = 0; gi < NDEV; gi++) begin : g_rdata
            assign dev_rdata_arr[gi] = bif.dev_rdata[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // Ids at or above NDEV select nothing; ISSUE treats them as a miss.
    assign did_ok = bif.bus_hit && (int'(bif.bus_did) < NDEV);

    always_comb begin
        issue_ack  = 1'b0;
        issue_data = '0;
        wait_ack   = 1'b0;
        wait_data  = '0;
        for (int k = 0; k < NDEV; k++) begin
            if (bif.bus_did == 3'(k)) begin
                issue_ack  = bif.dev_ack[k];
                issue_data = dev_rdata_arr[k];
            end
            if (sel_q == 3'(k)) begin
                wait_ack  = bif.dev_ack[k];
                wait_data = dev_rdata_arr[k];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        rsp_did_d   = rsp_did_q;
        bus_rd_d    = bus_rd_q;
        bus_wr_d    = bus_wr_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        sel_d       = sel_q;
`ifdef BUS_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (bif.req_valid) begin
                    state_d     = ISSUE;
                    req_ready_d = 1'b0;
                    bus_rd_d    = !bif.req_we;
                    bus_wr_d    = bif.req_we;
                    bus_addr_d  = bif.req_addr;
                    bus_wdata_d = bif.req_wdata;
                end
            end
            ISSUE: begin
                if (!did_ok) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                    rsp_did_d   = 3'd0;
                    bus_rd_d    = 1'b0;
                    bus_wr_d    = 1'b0;
                end else begin
                    sel_d = bif.bus_did;
                    if (issue_ack) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = bus_wr_q ? '0 : issue_data;
                        rsp_err_d   = 1'b0;
                        rsp_did_d   = bif.bus_did;
                        bus_rd_d    = 1'b0;
                        bus_wr_d    = 1'b0;
                    end else begin
                        state_d = WAIT;
`ifdef BUS_TIMEOUT_EN
                        cnt_d   = '0;
`endif
                    end
                end
            end
            WAIT: begin
                // An ack in the expiry cycle still completes the access cleanly.
                if (wait_ack) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = bus_wr_q ? '0 : wait_data;
                    rsp_err_d   = 1'b0;
                    rsp_did_d   = sel_q;
                    bus_rd_d    = 1'b0;
                    bus_wr_d    = 1'b0;
                end
`ifdef BUS_TIMEOUT_EN
                else if (cnt_q + 1'b1 == CNT_W'(TIMEOUT)) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                    rsp_did_d   = sel_q;
                    bus_rd_d    = 1'b0;
                    bus_wr_d    = 1'b0;
                    cnt_d       = cnt_q + 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            RESP: begin
                if (bif.rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            rsp_did_q   <= 3'd0;
            bus_rd_q    <= 1'b0;
            bus_wr_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            sel_q       <= 3'd0;
`ifdef BUS_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            rsp_did_q   <= rsp_did_d;
            bus_rd_q    <= bus_rd_d;
            bus_wr_q    <= bus_wr_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            sel_q       <= sel_d;
`ifdef BUS_TIMEOUT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign bif.req_ready = req_ready_q;
    assign bif.rsp_valid = rsp_valid_q;
    assign bif.rsp_rdata = rsp_rdata_q;
    assign bif.rsp_err   = rsp_err_q;
    assign bif.rsp_did   = rsp_did_q;
    assign bif.bus_rd    = bus_rd_q;
    assign bif.bus_wr    = bus_wr_q;
    assign bif.bus_addr  = bus_addr_q;
    assign bif.bus_wdata = bus_wdata_q;
endmodule

// File: tb/tb_bus_master.sv
// Scoreboard bench for bus_master: address-nibble decoder model, scripted device acks.
// Builds with or without BUS_TIMEOUT_EN.
module tb_bus_master;
    localparam int TMO = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bus_master_if #(.ADDR_W(16), .DATA_W(16), .NDEV(7)) bif ();

    bus_master #(.ADDR_W(16), .DATA_W(16), .NDEV(7), .TIMEOUT(TMO)) u_dut (
        .clk (clk),
        .rst (rst),
        .bif (bif)
    );

    // Decoder: bits [15:12] 0..6 select that device, anything else misses.
    assign bif.bus_hit = (bif.bus_rd || bif.bus_wr) && (bif.bus_addr[15:12] < 4'd7);
    assign bif.bus_did = bif.bus_hit ? bif.bus_addr[14:12] : 3'd0;

    typedef struct {
        logic [15:0] rdata;
        logic        err;
        logic [2:0]  did;
        int          lat;
        int          strobes;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] dev_val(input int k);
        return (k == 1) ? 16'hBEEF : (16'hD000 | 16'(k));
    endfunction

    // ack_wait: strobe-cycle index (0 = ISSUE) on which ack_dev acks, <0 = never.
    task automatic run_txn(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                           input int ack_dev, input int ack_wait, input int spur_dev,
                           input int rsp_hold, input int budget, input bit expect_rsp);
        exp_t e;
        exp_t g;
        int   strobes = 0;
        int   lat = 0;
        bit   done = 0;
        bit   miss = (addr[15:12] >= 4'd7);
        bit   late_rsp = 0;
        int   did = miss ? 0 : int'(addr[14:12]);
        if (miss)
            e = '{16'h0, 1'b1, 3'd0, 2, 1};
        else if (ack_wait < 0)
            e = '{16'h0, 1'b1, 3'(did), 2 + TMO, 1 + TMO};
        else
            e = '{we ? 16'h0 : dev_val(did), 1'b0, 3'(did), 2 + ack_wait, 1 + ack_wait};
        if (expect_rsp) exp_q.push_back(e);

        @(negedge clk);
        check_eq("req_ready_idle", 32'(bif.req_ready), 32'd1);
        bif.req_valid = 1'b1;
        bif.req_we    = we;
        bif.req_addr  = addr;
        bif.req_wdata = wdata;
        @(posedge clk);
        for (int k = 1; k <= budget && !done; k++) begin
            @(negedge clk);
            bif.req_valid = 1'b0;
            bif.dev_ack   = '0;
            if (bif.rsp_valid) begin
                done = 1;
                lat  = k;
            end else begin
                if (bif.bus_rd || bif.bus_wr) begin
                    if (strobes == 0) begin
                        check_eq("bus_rd", 32'(bif.bus_rd), 32'(!we));
                        check_eq("bus_wr", 32'(bif.bus_wr), 32'(we));
                        check_eq("bus_addr", 32'(bif.bus_addr), 32'(addr));
                        if (we) check_eq("bus_wdata", 32'(bif.bus_wdata), 32'(wdata));
                    end
                    if (bif.bus_rd && bif.bus_wr) check_eq("strobe_excl", 32'd1, 32'd0);
                    if (ack_wait >= 0 && strobes == ack_wait) bif.dev_ack[ack_dev] = 1'b1;
                    if (spur_dev >= 0 && strobes == 1) bif.dev_ack[spur_dev] = 1'b1;
                    strobes++;
                end
                @(posedge clk);
            end
        end

        if (expect_rsp) begin
            g = exp_q.pop_front();
            check_eq("rsp_seen", 32'(done), 32'd1);
            if (done) begin
                check_eq("rsp_rdata", 32'(bif.rsp_rdata), 32'(g.rdata));
                check_eq("rsp_err", 32'(bif.rsp_err), 32'(g.err));
                check_eq("rsp_did", 32'(bif.rsp_did), 32'(g.did));
                check_eq("latency", 32'(lat), 32'(g.lat));
                check_eq("strobe_cycles", 32'(strobes), 32'(g.strobes));
                for (int h = 0; h < rsp_hold; h++) begin
                    @(posedge clk);
                    @(negedge clk);
                    check_eq("hold_valid", 32'(bif.rsp_valid), 32'd1);
                    check_eq("hold_rdata", 32'(bif.rsp_rdata), 32'(g.rdata));
                    check_eq("hold_did", 32'(bif.rsp_did), 32'(g.did));
                    check_eq("hold_strobes", 32'({bif.bus_rd, bif.bus_wr}), 32'd0);
                    check_eq("hold_req_ready", 32'(bif.req_ready), 32'd0);
                end
                bif.rsp_ready = 1'b1;
                @(posedge clk);
                @(negedge clk);
                bif.rsp_ready = 1'b0;
                check_eq("post_rsp_ready", 32'(bif.req_ready), 32'd1);
                check_eq("post_rsp_valid", 32'(bif.rsp_valid), 32'd0);
            end
        end else begin
            if (!done) @(negedge clk);
            check_eq("no_rsp", 32'(done), 32'd0);
            check_eq("still_waiting", 32'(bif.bus_rd || bif.bus_wr), 32'd1);
            rst = 1'b1;
            @(posedge clk);
            @(negedge clk);
            rst = 1'b0;
            check_eq("rst_strobes", 32'({bif.bus_rd, bif.bus_wr}), 32'd0);
            check_eq("rst_req_ready", 32'(bif.req_ready), 32'd1);
            for (int h = 0; h < 10; h++) begin
                if (bif.rsp_valid) late_rsp = 1;
                @(negedge clk);
            end
            check_eq("rst_no_rsp", 32'(late_rsp), 32'd0);
        end
        $display("txn we=%0d addr=%04h wdata=%04h done=%0d lat=%0d strobes=%0d rdata=%04h err=%0d did=%0d",
                 we, addr, wdata, done, lat, strobes, bif.rsp_rdata, bif.rsp_err, bif.rsp_did);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bif.req_valid = 1'b0;
        bif.req_we    = 1'b0;
        bif.req_addr  = '0;
        bif.req_wdata = '0;
        bif.rsp_ready = 1'b0;
        bif.dev_ack   = '0;
        for (int k = 0; k < 7; k++) bif.dev_rdata[k*16 +: 16] = dev_val(k);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_req_ready", 32'(bif.req_ready), 32'd1);
        check_eq("rst_rsp_valid", 32'(bif.rsp_valid), 32'd0);
        check_eq("rst_rsp_rdata", 32'(bif.rsp_rdata), 32'd0);
        check_eq("rst_rsp_err", 32'(bif.rsp_err), 32'd0);
        check_eq("rst_rsp_did", 32'(bif.rsp_did), 32'd0);
        check_eq("rst_bus_strobes", 32'({bif.bus_rd, bif.bus_wr}), 32'd0);
        check_eq("rst_bus_addr", 32'(bif.bus_addr), 32'd0);
        check_eq("rst_bus_wdata", 32'(bif.bus_wdata), 32'd0);
        rst = 1'b0;

        run_txn(1'b0, 16'h1ABC, 16'h0000, 1, 1, -1, 0, 40, 1'b1);
        run_txn(1'b1, 16'h6FFF, 16'h1234, 6, 0, -1, 5, 40, 1'b1);
        run_txn(1'b0, 16'hF000, 16'h0000, -1, -1, -1, 0, 40, 1'b1);
`ifdef BUS_TIMEOUT_EN
        run_txn(1'b0, 16'h2000, 16'h0000, 2, -1, 3, 0, 40, 1'b1);
`else
        run_txn(1'b0, 16'h2000, 16'h0000, 2, -1, 3, 0, 100, 1'b0);
`endif
        run_txn(1'b0, 16'h3000, 16'h0000, 3, -1, -1, 0, 4, 1'b0);
        run_txn(1'b0, 16'h0000, 16'h0000, 0, 0, -1, 0, 40, 1'b1);
        run_txn(1'b1, 16'h4321, 16'hCAFE, 4, 3, -1, 2, 40, 1'b1);
        run_txn(1'b0, 16'h5000, 16'h0000, 5, 2, 4, 0, 40, 1'b1);
        run_txn(1'b1, 16'h8000, 16'h5555, -1, -1, -1, 0, 40, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
